debug_dump_ctrl: RTL and testbench
==================================

Name: debug_dump_ctrl

Overview:
- Host-side controller for the RV32 core debug port: drives debug_en, debug_step and debug_addr, and reads back debug_data.
- On request it optionally single-steps the frozen core, then sweeps debug_addr from 0 to NUM_WORDS-1.
- Each captured word is presented on a valid/ready stream for a downstream UART or display serializer.
- Sits at board top level, between the core and the debug transport.

Parameters:
- NUM_WORDS, 64, number of debug addresses swept per dump (1..128).
- SETTLE_CYCLES, 2, cycles debug_addr is held stable before debug_data is sampled (>=1).
- STEP_CYCLES, 4, length in cycles of each of the debug_step high phase and low phase (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- freeze  in  1  level request to place the core in debug-clock mode.
- start  in  1  one-cycle request to begin a dump.
- step_req  in  1  sampled with start; 1 = step the core once before dumping.
- debug_en  out  1  to core; registered copy of freeze.
- debug_step  out  1  to core; step clock pulse.
- debug_addr  out  7  to core; current read address.
- debug_data  in  32  from core; combinational read data.
- out_data  out  32  captured word.
- out_addr  out  7  address that out_data was read from.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters 0. Reset mid-dump aborts immediately, with no done pulse.
- debug_en <= freeze every cycle, independent of the FSM.
- FSM states: IDLE, STEP_HI, STEP_LO, SETTLE, SEND, FIN.
- IDLE:
  - If start=1, latch step_req.
  - If step_req=1 and debug_en=1, go to STEP_HI; otherwise go to SETTLE.
  - On leaving IDLE, debug_addr <= 0. start is ignored in all other states.
- STEP_HI: debug_step=1 for exactly STEP_CYCLES cycles, then STEP_LO.
- STEP_LO: debug_step=0 for STEP_CYCLES cycles, then SETTLE. debug_addr stays 0.
- SETTLE:
  - Counter runs SETTLE_CYCLES cycles.
  - On the last cycle: out_data <= debug_data, out_addr <= debug_addr, out_valid <= 1, next state SEND.
- SEND:
  - out_valid, out_data and out_addr are held stable until out_valid & out_ready.
  - On that handshake cycle, out_valid <= 0.
  - If debug_addr == NUM_WORDS-1, go to FIN. Otherwise debug_addr <= debug_addr+1 and go to SETTLE (counter reset).
- FIN: done=1 for one cycle, then IDLE. busy=0 from the IDLE cycle on.
- Latency, step_req=0, out_ready tied 1:
  - start sampled at cycle t.
  - First out_valid at t+1+SETTLE_CYCLES.
  - Each subsequent word arrives SETTLE_CYCLES+1 cycles later.
  - done at last handshake +1.
- Latency with a step: add 2*STEP_CYCLES before SETTLE.
- debug_addr never exceeds NUM_WORDS-1 and never wraps. With NUM_WORDS=128 the last address is 127.
- freeze dropping mid-dump does not abort the dump; debug_en follows freeze.
- step_req=1 with freeze=0 is not an error: the step is skipped.
- start in the same cycle as FIN's done is ignored; start is accepted only in IDLE.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy=0.
- freeze=1, start with step_req=0, core regs x0..x3 = 0,5,6,7, NUM_WORDS=4, SETTLE_CYCLES=2, out_ready=1 ->
  - words (addr,data) = (0,0),(1,5),(2,6),(3,7).
  - first out_valid at t+3; words 3 cycles apart.
  - done one cycle after the 4th handshake; debug_step never high.
- freeze=1, start with step_req=1, STEP_CYCLES=4 ->
  - debug_step high exactly cycles t+1..t+4 and low t+5..t+8.
  - first out_valid at t+11.
  - dumped pc register reflects one retired instruction.
- out_ready toggled 0/1 randomly during dump ->
  - out_data/out_addr unchanged while valid and not ready.
  - no word lost or duplicated; addresses strictly 0..N-1.
- start pulses while busy, plus step_req=1 with freeze=0 ->
  - extra starts ignored; exactly one done per accepted start.
  - no debug_step pulse when freeze=0.
- rst asserted in SEND at addr 2 ->
  - next cycle all outputs 0 and FSM in IDLE, no done.
  - a new start restarts from addr 0.

Source files
------------

// File: rtl/debug_dump_ctrl.sv
// Host-side dump controller for the RV32 debug port: optionally single-steps the
// frozen core, then sweeps every debug address and streams each word out.
module debug_dump_ctrl #(
  parameter int NUM_WORDS     = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter int STEP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        start,
  input  logic        step_req,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic [31:0] out_data,
  output logic [6:0]  out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP_HI = 3'd1,
    STEP_LO = 3'd2,
    SETTLE  = 3'd3,
    SEND    = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [6:0]  LAST_ADDR   = 7'(NUM_WORDS - 1);
  localparam logic [15:0] STEP_LAST   = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  debug_addr_q, debug_addr_d;
  logic [31:0] out_data_q, out_data_d;
  logic [6:0]  out_addr_q, out_addr_d;
  logic        out_valid_q, out_valid_d;
  logic        debug_en_q, debug_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      debug_addr_q <= '0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      debug_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      debug_addr_q <= debug_addr_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      out_valid_q  <= out_valid_d;
      debug_en_q   <= debug_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    debug_addr_d = debug_addr_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    out_valid_d  = out_valid_q;
    debug_en_d   = freeze;

    case (state_q)
      IDLE: begin
        // A step is only meaningful while the core is already in debug-clock mode.
        if (start) begin
          debug_addr_d = '0;
          cnt_d        = '0;
          state_d      = (step_req && debug_en_q) ? STEP_HI : SETTLE;
        end
      end
      STEP_HI: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          state_d = STEP_LO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STEP_LO: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          out_data_d  = debug_data;
          out_addr_d  = debug_addr_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (debug_addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            debug_addr_d = debug_addr_q + 7'd1;
            cnt_d        = '0;
            state_d      = SETTLE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign debug_en   = debug_en_q;
  assign debug_step = (state_q == STEP_HI);
  assign debug_addr = debug_addr_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Self-checking bench for debug_dump_ctrl: a tiny four-register core model whose
// x3 advances by 4 on every step pulse seen while in debug-clock mode.
module tb_debug_dump_ctrl;

  localparam int NW     = 4;
  localparam int SETTLE = 2;
  localparam int STEP   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        start = 1'b0;
  logic        step_req = 1'b0;
  logic        out_ready = 1'b0;
  logic        debug_en, debug_step, out_valid, busy, done;
  logic [6:0]  debug_addr, out_addr;
  logic [31:0] debug_data, out_data;

  debug_dump_ctrl #(.NUM_WORDS(NW), .SETTLE_CYCLES(SETTLE), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .start(start), .step_req(step_req),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
    .debug_data(debug_data), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] x3 = 32'd7;
  logic        step_prev = 1'b0;
  always @(negedge clk) begin
    if (debug_en && debug_step && !step_prev) x3 = x3 + 32'd4;
    step_prev = debug_step;
  end

  always_comb begin
    debug_data = 32'hdead_beef;
    case (debug_addr)
      7'd0: debug_data = 32'd0;
      7'd1: debug_data = 32'd5;
      7'd2: debug_data = 32'd6;
      7'd3: debug_data = x3;
      default: debug_data = 32'hdead_beef;
    endcase
  end

  // Cumulative event log; each test snapshots the counters before it starts.
  int          hs_n = 0, step_n = 0, done_n = 0, done_cyc = 0;
  logic [6:0]  hs_addr [256];
  logic [31:0] hs_data [256];
  int          hs_cyc  [256];
  int          step_cyc[256];
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (hs_n < 256) begin
        hs_addr[hs_n] = out_addr;
        hs_data[hs_n] = out_data;
        hs_cyc[hs_n]  = cyc;
      end
      hs_n++;
    end
    if (debug_step) begin
      if (step_n < 256) step_cyc[step_n] = cyc;
      step_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  int tests_run = 0, tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic stp, output int t);
    start    = 1'b1;
    step_req = stp;
    t        = cyc;
    tick();
    start    = 1'b0;
    step_req = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget);
    int k;
    k = 0;
    while (done_n == db && k < budget) begin
      tick();
      k++;
    end
    if (done_n == db) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic check_words(input int hb, input logic [31:0] exp_x3);
    logic [31:0] exp_d [4];
    exp_d = '{32'd0, 32'd5, 32'd6, exp_x3};
    checkOutput("word_count", 32'(hs_n - hb), NW);
    for (int i = 0; i < NW; i++) begin
      checkOutput("word_addr", {25'd0, hs_addr[hb + i]}, i);
      checkOutput("word_data", hs_data[hb + i], exp_d[i]);
    end
  endtask

  task automatic run_dump(input logic frz, input logic stp, input int exp_first,
                          input int exp_steps, input logic [31:0] exp_x3);
    int t, hb, sb, db;
    freeze    = frz;
    out_ready = 1'b1;
    repeat (3) tick();
    hb = hs_n; sb = step_n; db = done_n;
    applyStimulus(stp, t);
    wait_done(db, 200);
    tick();
    check_words(hb, exp_x3);
    checkOutput("first_valid_lat", 32'(hs_cyc[hb] - t), exp_first);
    for (int i = 1; i < NW; i++)
      checkOutput("word_spacing", 32'(hs_cyc[hb + i] - hs_cyc[hb + i - 1]), SETTLE + 1);
    checkOutput("done_lat", 32'(done_cyc - hs_cyc[hb + NW - 1]), 1);
    checkOutput("done_count", 32'(done_n - db), 1);
    checkOutput("step_cycles", 32'(step_n - sb), exp_steps);
    if (exp_steps > 0) begin
      checkOutput("step_first", 32'(step_cyc[sb] - t), 1);
      checkOutput("step_last", 32'(step_cyc[sb + exp_steps - 1] - t), STEP);
    end
    checkOutput("busy_after", {31'd0, busy}, 0);
  endtask

  typedef struct {
    logic        frz;
    logic        stp;
    int          exp_first;
    int          exp_steps;
    logic [31:0] exp_x3;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    int          t, hb, db, k;
    logic        prev_hold;
    logic [6:0]  prev_a;
    logic [31:0] prev_d;

    vecs[0] = '{frz: 1'b1, stp: 1'b0, exp_first: 3,  exp_steps: 0, exp_x3: 32'd7};
    vecs[1] = '{frz: 1'b1, stp: 1'b1, exp_first: 11, exp_steps: 4, exp_x3: 32'd11};
    vecs[2] = '{frz: 1'b0, stp: 1'b1, exp_first: 3,  exp_steps: 0, exp_x3: 32'd11};
    vecs[3] = '{frz: 1'b1, stp: 1'b1, exp_first: 11, exp_steps: 4, exp_x3: 32'd15};

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("idle_debug_en", {31'd0, debug_en}, 0);
    checkOutput("idle_debug_step", {31'd0, debug_step}, 0);
    checkOutput("idle_debug_addr", {25'd0, debug_addr}, 0);
    checkOutput("idle_out_valid", {31'd0, out_valid}, 0);
    checkOutput("idle_out_data", out_data, 0);
    checkOutput("idle_out_addr", {25'd0, out_addr}, 0);
    checkOutput("idle_busy", {31'd0, busy}, 0);
    checkOutput("idle_done", {31'd0, done}, 0);

    for (int v = 0; v < 4; v++)
      run_dump(vecs[v].frz, vecs[v].stp, vecs[v].exp_first, vecs[v].exp_steps, vecs[v].exp_x3);

    // Random backpressure: a word must sit still until it is accepted.
    freeze = 1'b1; out_ready = 1'b0;
    hb = hs_n; db = done_n;
    applyStimulus(1'b0, t);
    prev_hold = 1'b0; prev_a = '0; prev_d = '0;
    for (k = 0; k < 400 && done_n == db; k++) begin
      @(negedge clk);
      if (prev_hold) begin
        checkOutput("hold_valid", {31'd0, out_valid}, 1);
        checkOutput("hold_addr", {25'd0, out_addr}, {25'd0, prev_a});
        checkOutput("hold_data", out_data, prev_d);
      end
      prev_hold = out_valid && !out_ready;
      prev_a = out_addr;
      prev_d = out_data;
      tick();
      out_ready = 1'($urandom_range(0, 1));
    end
    if (done_n == db) checkOutput("bp_timeout", 0, 1);
    out_ready = 1'b1;
    tick();
    check_words(hb, 32'd15);

    // Starts while busy (including the FIN cycle) must be ignored.
    hb = hs_n; db = done_n;
    applyStimulus(1'b0, t);
    for (k = 0; k < 200; k++) begin
      start = busy;
      tick();
      if (!busy && done_n > db) break;
    end
    start = 1'b0;
    repeat (20) tick();
    checkOutput("busy_start_done_count", 32'(done_n - db), 1);
    checkOutput("busy_start_idle", {31'd0, busy}, 0);
    check_words(hb, 32'd15);

    // Reset while word 2 is waiting in SEND.
    db = done_n;
    applyStimulus(1'b0, t);
    for (k = 0; k < 100; k++) begin
      if (out_valid && out_addr == 7'd2) break;
      tick();
    end
    out_ready = 1'b0;
    checkOutput("reach_addr2", {25'd0, out_addr}, 2);
    rst = 1'b1;
    tick();
    checkOutput("rst_debug_en", {31'd0, debug_en}, 0);
    checkOutput("rst_debug_step", {31'd0, debug_step}, 0);
    checkOutput("rst_debug_addr", {25'd0, debug_addr}, 0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_addr", {25'd0, out_addr}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("rst_no_done", 32'(done_n - db), 0);
    run_dump(1'b1, 1'b0, 3, 0, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
